branch_checkpoint_ctrl: RTL and testbench

Controller that owns the branch checkpoints feeding the rename map table's recovery port. It allocates one age-ordered checkpoint slot per dispatched branch and stores that branch's map snapshot. On a correct resolution it frees the slot. On a mispredict it drives the saved map and a one-cycle recovery strobe into the map table, and squashes the mispredicted branch's checkpoint together with every younger one. It sits between dispatch, the branch-resolve path in complete, and the map table.

---
 rtl/branch_checkpoint_ctrl.sv | 123 ++++++++++++
 tb/tb_branch_checkpoint_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_checkpoint_ctrl.sv
`default_nettype none
// ============================================================================
// branch_checkpoint_ctrl : age-ordered branch map checkpoints with recovery
// Revision 1.0
// ============================================================================
module branch_checkpoint_ctrl #(
    parameter int N_CKPT          = 4,
    parameter int N_ARCH_REG      = 32,
    parameter int N_PHYS_REG_BITS = 6,
    parameter int TAG_W           = $clog2(N_CKPT)
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    alloc_req,
    input  logic [N_ARCH_REG*N_PHYS_REG_BITS-1:0]   alloc_map,
    output logic                                    alloc_gnt,
    output logic [TAG_W-1:0]                        alloc_tag,
    output logic                                    full,
    input  logic                                    resolve_valid,
    input  logic [TAG_W-1:0]                        resolve_tag,
    input  logic                                    resolve_mispredict,
    output logic                                    recover_enable,
    output logic [N_ARCH_REG*N_PHYS_REG_BITS-1:0]   recover_map,
    output logic [N_CKPT-1:0]                       squash_mask,
    output logic [N_CKPT-1:0]                       pending_mask
);

    localparam int MAP_W = N_ARCH_REG * N_PHYS_REG_BITS;

    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;
    logic [N_CKPT-1:0] pending_q, pending_d;
    logic [MAP_W-1:0]  snap_q [N_CKPT];
    logic              recover_enable_q;
    logic [MAP_W-1:0]  recover_map_q;
    logic [N_CKPT-1:0] squash_mask_q, squash_d;

    logic              w_mispredict;
    logic              w_correct;
    logic              w_retire;
    logic              w_gnt;
    logic [TAG_W-1:0]  w_dist;

    assign w_mispredict = resolve_valid & resolve_mispredict & pending_q[resolve_tag];
    assign w_correct    = resolve_valid & ~resolve_mispredict & pending_q[resolve_tag];
    assign w_retire     = (count_q != '0) & ~pending_q[head_q];
    assign full         = (count_q == (TAG_W+1)'(N_CKPT));
    assign w_gnt        = alloc_req & ~full & ~recover_enable_q & ~w_mispredict;
    assign w_dist       = resolve_tag - head_q;

    assign alloc_gnt      = w_gnt;
    assign alloc_tag      = tail_q;
    assign pending_mask   = pending_q;
    assign recover_enable = recover_enable_q;
    assign recover_map    = recover_map_q;
    assign squash_mask    = squash_mask_q;

    // A slot is squashed when its age offset from head lies in [dist, count);
    // working in offsets keeps the full (head == tail) case unambiguous.
    always_comb begin
        squash_d = '0;
        for (int i = 0; i < N_CKPT; i++) begin
            squash_d[i] = ((TAG_W'(i) - head_q) >= w_dist) &&
                          ({1'b0, TAG_W'(i) - head_q} < count_q);
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (w_correct)
            pending_d[resolve_tag] = 1'b0;
        if (w_mispredict)
            pending_d = pending_d & ~squash_d;
        if (w_gnt)
            pending_d[tail_q] = 1'b1;

        head_d = w_retire ? head_q + TAG_W'(1) : head_q;

        tail_d = tail_q;
        if (w_mispredict)
            tail_d = resolve_tag;
        else if (w_gnt)
            tail_d = tail_q + TAG_W'(1);

        count_d = count_q;
        if (w_mispredict)
            count_d = {1'b0, w_dist};
        else if (w_gnt)
            count_d = count_q + (TAG_W+1)'(1);
        if (w_retire)
            count_d = count_d - (TAG_W+1)'(1);
    end

    always_ff @(posedge clock) begin
        if (w_gnt)
            snap_q[tail_q] <= alloc_map;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            pending_q        <= '0;
            recover_enable_q <= 1'b0;
            recover_map_q    <= '0;
            squash_mask_q    <= '0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            pending_q        <= pending_d;
            recover_enable_q <= w_mispredict;
            if (w_mispredict) begin
                recover_map_q <= snap_q[resolve_tag];
                squash_mask_q <= squash_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_checkpoint_ctrl.sv
`default_nettype none
// ============================================================================
// tb_branch_checkpoint_ctrl : scoreboard bench with an age-queue reference model
// Revision 1.0
// ============================================================================
module tb_branch_checkpoint_ctrl;

    localparam int N     = 4;
    localparam int TAG_W = 2;
    localparam int MAP_W = 32 * 6;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             alloc_req = 1'b0;
    logic [MAP_W-1:0] alloc_map = '0;
    logic             alloc_gnt;
    logic [TAG_W-1:0] alloc_tag;
    logic             full;
    logic             resolve_valid = 1'b0;
    logic [TAG_W-1:0] resolve_tag = '0;
    logic             resolve_mispredict = 1'b0;
    logic             recover_enable;
    logic [MAP_W-1:0] recover_map;
    logic [N-1:0]     squash_mask;
    logic [N-1:0]     pending_mask;

    branch_checkpoint_ctrl #(
        .N_CKPT(N), .N_ARCH_REG(32), .N_PHYS_REG_BITS(6), .TAG_W(TAG_W)
    ) dut (
        .clock(clock), .reset(reset),
        .alloc_req(alloc_req), .alloc_map(alloc_map),
        .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag), .full(full),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
        .resolve_mispredict(resolve_mispredict),
        .recover_enable(recover_enable), .recover_map(recover_map),
        .squash_mask(squash_mask), .pending_mask(pending_mask)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [TAG_W-1:0] tag;
        bit               resolved;
        logic [MAP_W-1:0] map;
    } ent_t;

    typedef struct {
        bit               chk;
        bit               gnt;
        logic [TAG_W-1:0] tag;
        bit               full;
        logic [N-1:0]     pend;
        bit               ren;
        logic [MAP_W-1:0] rmap;
        logic [N-1:0]     smask;
    } exp_t;

    // Reference: in-flight branches kept oldest-first; tags are handed out in order.
    ent_t             q[$];
    logic [TAG_W-1:0] m_tail;
    bit               m_ren;
    logic [MAP_W-1:0] m_rmap;
    logic [N-1:0]     m_smask;
    exp_t             exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [MAP_W-1:0] act, input logic [MAP_W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                chk("alloc_gnt", MAP_W'(alloc_gnt), MAP_W'(e.gnt));
                if (e.gnt)
                    chk("alloc_tag", MAP_W'(alloc_tag), MAP_W'(e.tag));
                chk("full", MAP_W'(full), MAP_W'(e.full));
                chk("pending_mask", MAP_W'(pending_mask), MAP_W'(e.pend));
                chk("recover_enable", MAP_W'(recover_enable), MAP_W'(e.ren));
                chk("recover_map", recover_map, e.rmap);
                chk("squash_mask", MAP_W'(squash_mask), MAP_W'(e.smask));
            end
        end
    end

    function automatic logic [MAP_W-1:0] pat_map(input int k);
        logic [MAP_W-1:0] m;
        for (int i = 0; i < 32; i++) m[i*6 +: 6] = 6'(i + k);
        return m;
    endfunction

    function automatic logic [MAP_W-1:0] rand_map();
        logic [MAP_W-1:0] m;
        for (int i = 0; i < MAP_W/32; i++) m[i*32 +: 32] = $urandom;
        return m;
    endfunction

    task automatic step(input bit rq, input logic [MAP_W-1:0] m, input bit rv,
                        input logic [TAG_W-1:0] rt, input bit rm, input bit rs);
        exp_t e;
        logic [N-1:0] pend;
        int idx;
        bit mis, cor, gnt, retire;
        @(posedge clock);
        #1;
        reset = rs; alloc_req = rq; alloc_map = m;
        resolve_valid = rv; resolve_tag = rt; resolve_mispredict = rm;

        pend = '0;
        idx = -1;
        for (int j = 0; j < q.size(); j++) begin
            if (!q[j].resolved) pend[q[j].tag] = 1'b1;
            if (q[j].tag == rt && !q[j].resolved) idx = j;
        end
        mis = rv && rm && (idx >= 0);
        cor = rv && !rm && (idx >= 0);
        gnt = rq && (q.size() < N) && !m_ren && !mis;
        e = '{chk: !rs, gnt: gnt, tag: m_tail, full: (q.size() == N), pend: pend,
              ren: m_ren, rmap: m_rmap, smask: m_smask};
        exp_q.push_back(e);

        if (rs) begin
            q.delete();
            m_tail = '0; m_ren = 0; m_rmap = '0; m_smask = '0;
            return;
        end
        retire = (q.size() > 0) && q[0].resolved;
        m_ren = mis;
        if (mis) begin
            m_rmap  = q[idx].map;
            m_smask = '0;
            for (int j = idx; j < q.size(); j++) m_smask[q[j].tag] = 1'b1;
            while (q.size() > idx) void'(q.pop_back());
            m_tail = rt;
        end
        if (cor) q[idx].resolved = 1'b1;
        if (retire) void'(q.pop_front());
        if (gnt) begin
            q.push_back('{tag: m_tail, resolved: 1'b0, map: m});
            m_tail = m_tail + TAG_W'(1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0);
    endtask

    initial begin
        step(0, '0, 0, '0, 0, 1);
        idle(1);
        // Fill, overflow attempt, correct resolve of tag 0, wrap allocation.
        for (int k = 0; k < 4; k++) step(1, pat_map(k), 0, '0, 0, 0);
        step(1, pat_map(9), 0, '0, 0, 0);
        step(0, '0, 1, 2'd0, 0, 0);
        idle(1);
        step(1, pat_map(7), 0, '0, 0, 0);
        idle(1);

        // Mispredict of tag 1 coincident with alloc_req, then alloc during recovery.
        step(0, '0, 0, '0, 0, 1);
        for (int k = 0; k < 4; k++) step(1, pat_map(k), 0, '0, 0, 0);
        step(1, pat_map(20), 1, 2'd1, 1, 0);
        step(1, pat_map(21), 0, '0, 0, 0);
        step(1, pat_map(22), 0, '0, 0, 0);
        idle(1);

        // Out-of-order correct resolves drain one per cycle once head resolves.
        step(0, '0, 0, '0, 0, 1);
        for (int k = 0; k < 4; k++) step(1, pat_map(k + 3), 0, '0, 0, 0);
        step(0, '0, 1, 2'd2, 0, 0);
        step(0, '0, 1, 2'd1, 0, 0);
        idle(1);
        step(0, '0, 1, 2'd0, 0, 0);
        idle(4);

        // Non-pending resolves, then reset landing in the recovery cycle.
        step(0, '0, 1, 2'd3, 0, 0);
        step(0, '0, 1, 2'd2, 1, 0);
        step(1, pat_map(30), 0, '0, 0, 0);
        step(1, pat_map(31), 0, '0, 0, 0);
        step(0, '0, 1, 2'd0, 1, 0);
        step(0, '0, 0, '0, 0, 1);
        idle(2);

        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 9) < 7, rand_map(), $urandom_range(0, 1) == 1,
                 TAG_W'($urandom_range(0, N-1)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 199) == 0);
        end

        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
